// File: rtl/autofire_multi.sv
// Multi-channel turbo generator: per-button pass-through, free-running burst, or
// bursts locked to a shared global phase, at one of four run-time rates.

module autofire_lane #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          btn,
  input  logic          af_en,
  input  logic          sync_mode,
  input  logic          gphase,
  input  logic [CW-1:0] hm1_sel,
  output logic          out
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] timer, timer_n;
  logic [CW-1:0] hm1, hm1_n;
  logic          out_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      timer <= '0;
      hm1   <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      hm1   <= hm1_n;
      out   <= out_n;
    end
  end

  // hm1 holds the latched half-period minus one, so it always fits CW bits.
  always_comb begin
    state_n = state;
    timer_n = timer;
    hm1_n   = hm1;
    out_n   = out;
    if (!af_en) begin
      state_n = IDLE;
      timer_n = '0;
      out_n   = btn;
    end else if (sync_mode) begin
      state_n = IDLE;
      timer_n = '0;
      out_n   = btn & gphase;
    end else if (!btn) begin
      state_n = IDLE;
      timer_n = '0;
      out_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = HIGH;
          timer_n = '0;
          hm1_n   = hm1_sel;
          out_n   = 1'b1;
        end
        HIGH, LOW: begin
          if (timer == hm1) begin
            state_n = (state == HIGH) ? LOW : HIGH;
            timer_n = '0;
            hm1_n   = hm1_sel;
            out_n   = (state == LOW);
          end else begin
            timer_n = timer + 1'b1;
            out_n   = (state == HIGH);
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
          out_n   = 1'b0;
        end
      endcase
    end
  end
endmodule

module autofire_multi #(
  parameter int FREQ  = 37_800_000,
  parameter int NCH   = 8,
  parameter int RATE0 = 30,
  parameter int RATE1 = 15,
  parameter int RATE2 = 10,
  parameter int RATE3 = 5
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [NCH-1:0] btn,
  input  logic [NCH-1:0] af_en,
  input  logic [1:0]     rate_sel,
  input  logic           sync_mode,
  output logic [NCH-1:0] out
);
  localparam int H0   = FREQ / RATE0 / 2;
  localparam int H1   = FREQ / RATE1 / 2;
  localparam int H2   = FREQ / RATE2 / 2;
  localparam int H3   = FREQ / RATE3 / 2;
  localparam int HA   = (H0 > H1) ? H0 : H1;
  localparam int HB   = (H2 > H3) ? H2 : H3;
  localparam int HMAX = (HA > HB) ? HA : HB;
  localparam int CW   = (HMAX > 2) ? $clog2(HMAX) : 1;

  if (H0 < 2 || H1 < 2 || H2 < 2 || H3 < 2) begin : g_bad_rate
    $error("autofire_multi: every half-period must be at least 2 cycles");
  end

  logic [CW-1:0] hm1_sel;
  logic [CW-1:0] gtimer, ghm1;
  logic          gphase;

  always_comb begin
    hm1_sel = CW'(H0 - 1);
    case (rate_sel)
      2'd1:    hm1_sel = CW'(H1 - 1);
      2'd2:    hm1_sel = CW'(H2 - 1);
      2'd3:    hm1_sel = CW'(H3 - 1);
      default: hm1_sel = CW'(H0 - 1);
    endcase
  end

  // Global phase generator; rate is only re-sampled at a half-period wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gtimer <= '0;
      ghm1   <= CW'(H0 - 1);
      gphase <= 1'b0;
    end else if (gtimer == ghm1) begin
      gtimer <= '0;
      ghm1   <= hm1_sel;
      gphase <= ~gphase;
    end else begin
      gtimer <= gtimer + 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    autofire_lane #(.CW(CW)) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .btn       (btn[c]),
      .af_en     (af_en[c]),
      .sync_mode (sync_mode),
      .gphase    (gphase),
      .hm1_sel   (hm1_sel),
      .out       (out[c])
    );
  end
endmodule
